// File: rtl/neurram_spi_pkg.sv
// Shared FSM state encoding and image-geometry helpers for the NeuRRAM serial-chain engine.
package neurram_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_UNLOAD   = 3'd4
  } state_t;

  // 32-bit words needed to hold one image across all lanes
  function automatic int calc_wpc(input int chain_len, input int lanes);
    return (chain_len * lanes) / 32;
  endfunction

  // Bits each lane contributes to one 32-bit word
  function automatic int calc_bpw(input int lanes);
    return 32 / lanes;
  endfunction

endpackage

// File: rtl/neurram_spi_clkgen.sv
// Half-period counter: strobes phase_end on the last clk of each spi_clk half, toggles registered spi_clk.
// No backpressure; clr (idle/abort) or !en parks the counter and forces spi_clk low.
module neurram_spi_clkgen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic phase_end,
  output logic spi_clk
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign phase_end = en && !clr && (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      spi_clk <= 1'b0;
    end else if (clr || !en) begin
      cnt     <= '0;
      spi_clk <= 1'b0;
    end else if (phase_end) begin
      cnt     <= '0;
      spi_clk <= ~spi_clk;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/neurram_spi_engine.sv
// Multi-lane scan-chain controller: load images from in stream, shift on LANES lines, unload to out stream.
// One word/cycle on both streams with valid/ready stalls; NEURRAM_SPI_SNAPSHOT_EN adds the lane-0 snapshot port.
module neurram_spi_engine
  import neurram_spi_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int CHAIN_LEN = 256,
  parameter int CLK_DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cfg_write,
  input  logic             cfg_read,
  input  logic [3:0]       shift_mult,
  input  logic [3:0]       in_steps,
  input  logic [3:0]       out_steps,
  output logic             busy,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             spi_clk,
  output logic [LANES-1:0] shift_out,
  input  logic [LANES-1:0] shift_in
`ifdef NEURRAM_SPI_SNAPSHOT_EN
  ,
  output logic [CHAIN_LEN-1:0] snapshot
`endif
);

  localparam int WPC = calc_wpc(CHAIN_LEN, LANES);
  localparam int BPW = calc_bpw(LANES);
  localparam int WCW = $clog2(WPC + 1);
  localparam int BCW = $clog2(CHAIN_LEN * 15 + 1);
  localparam logic [CHAIN_LEN-1:0] LANE_MASK = CHAIN_LEN'({BPW{1'b1}});

  state_t               state;
  logic [WCW-1:0]       word_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic [3:0]           in_cnt;
  logic [3:0]           out_cnt;
  logic [CHAIN_LEN-1:0] tx [LANES];
  logic [CHAIN_LEN-1:0] rx [LANES];

  logic [3:0]     mult_eff, in_eff, out_eff;
  logic [BCW-1:0] bit_last;
  logic [31:0]    word_off;
  logic           word_last, phase_end, shift_done, clk_clr, clk_en;
  logic [BPW-1:0] in_lane  [LANES];
  logic [BPW-1:0] out_lane [LANES];

  assign mult_eff  = (shift_mult == 4'd0) ? 4'd1 : shift_mult;
  assign in_eff    = (in_steps == 4'd0) ? 4'd1 : in_steps;
  assign out_eff   = (out_steps == 4'd0) ? 4'd1 : out_steps;
  assign bit_last  = BCW'(CHAIN_LEN) * BCW'(mult_eff) - BCW'(1);
  assign word_off  = 32'(word_cnt) * 32'(BPW);
  assign word_last = (word_cnt == WCW'(WPC - 1));

  assign busy      = (state != ST_IDLE);
  assign in_ready  = (state == ST_LOAD) && !abort;
  assign out_valid = (state == ST_UNLOAD) && !abort;

  assign clk_clr    = (state == ST_IDLE) || abort;
  assign clk_en     = (state == ST_SHIFT_LO) || (state == ST_SHIFT_HI);
  assign shift_done = !abort && (state == ST_SHIFT_HI) && phase_end && (bit_cnt == bit_last);

  neurram_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk       (clk),
    .rst       (rst),
    .clr       (clk_clr),
    .en        (clk_en),
    .phase_end (phase_end),
    .spi_clk   (spi_clk)
  );

  // Word bit LANES*i+l <-> lane l, chain bit word_cnt*BPW+i
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [CHAIN_LEN-1:0] rx_word;
    assign rx_word      = rx[l] >> word_off;
    assign out_lane[l]  = (state == ST_UNLOAD) ? rx_word[BPW-1:0] : '0;
    assign shift_out[l] = tx[l][0];
    for (genvar i = 0; i < BPW; i++) begin : g_bit
      assign in_lane[l][i]        = in_data[LANES*i+l];
      assign out_data[LANES*i+l]  = out_lane[l][i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
      bit_cnt  <= '0;
      in_cnt   <= '0;
      out_cnt  <= '0;
      for (int l = 0; l < LANES; l++) begin
        tx[l] <= '0;
        rx[l] <= '0;
      end
    end else if (abort) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= cfg_write ? ST_LOAD : ST_SHIFT_LO;
            word_cnt <= '0;
            bit_cnt  <= '0;
            in_cnt   <= '0;
            out_cnt  <= '0;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            for (int l = 0; l < LANES; l++)
              tx[l] <= (tx[l] & ~(LANE_MASK << word_off)) | (CHAIN_LEN'(in_lane[l]) << word_off);
            if (word_last) begin
              word_cnt <= '0;
              in_cnt   <= in_cnt + 4'd1;
              state    <= ST_SHIFT_LO;
            end else begin
              word_cnt <= word_cnt + WCW'(1);
            end
          end
        end
        ST_SHIFT_LO: begin
          if (phase_end) begin
            for (int l = 0; l < LANES; l++)
              rx[l] <= (rx[l] >> 1) | (CHAIN_LEN'(shift_in[l]) << (CHAIN_LEN - 1));
            state <= ST_SHIFT_HI;
          end
        end
        ST_SHIFT_HI: begin
          if (phase_end) begin
            for (int l = 0; l < LANES; l++)
              tx[l] <= tx[l] >> 1;
            if (bit_cnt == bit_last) begin
              bit_cnt <= '0;
              if (cfg_write && (in_cnt < in_eff)) state <= ST_LOAD;
              else if (cfg_read)                  state <= ST_UNLOAD;
              else                                state <= ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
              state   <= ST_SHIFT_LO;
            end
          end
        end
        ST_UNLOAD: begin
          if (out_ready) begin
            if (word_last) begin
              word_cnt <= '0;
              out_cnt  <= out_cnt + 4'd1;
              state    <= ((out_cnt + 4'd1) >= out_eff) ? ST_IDLE : ST_SHIFT_LO;
            end else begin
              word_cnt <= word_cnt + WCW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef NEURRAM_SPI_SNAPSHOT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             snapshot <= '0;
    else if (shift_done) snapshot <= rx[0];
  end
`else
  logic unused_shift_done;
  assign unused_shift_done = shift_done;
`endif

endmodule

// File: tb/tb_neurram_spi_engine.sv
// Scoreboarded bench for neurram_spi_engine: 2-lane/256-bit/div-1 and 4-lane/128-bit/div-3 instances, loopback wired.
module tb_neurram_spi_engine;

  localparam int LANES_A = 2, CL_A = 256, DIV_A = 1;
  localparam int WPC_A = CL_A * LANES_A / 32, BPW_A = 32 / LANES_A;
  localparam int LANES_B = 4, CL_B = 128, DIV_B = 3;
  localparam int WPC_B = CL_B * LANES_B / 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic abort = 1'b0, cfg_write = 1'b0, cfg_read = 1'b0;
  logic [3:0] shift_mult = 4'd1, in_steps = 4'd1, out_steps = 4'd1;
  logic [31:0] in_data = '0;

  logic start_a = 1'b0, in_valid_a = 1'b0, out_ready_a = 1'b1;
  logic busy_a, in_ready_a, out_valid_a, spi_clk_a;
  logic [31:0] out_data_a;
  logic [LANES_A-1:0] shift_out_a, shift_in_a;

  logic start_b = 1'b0, in_valid_b = 1'b0, out_ready_b = 1'b1;
  logic busy_b, in_ready_b, out_valid_b, spi_clk_b;
  logic [31:0] out_data_b;
  logic [LANES_B-1:0] shift_out_b, shift_in_b;

`ifdef NEURRAM_SPI_SNAPSHOT_EN
  logic [CL_A-1:0] snapshot_a;
  logic [CL_B-1:0] snapshot_b;
`endif

  assign shift_in_a = shift_out_a;
  assign shift_in_b = shift_out_b;

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0]        exp_q[$];
  logic [LANES_A-1:0] bit_q[$];

  neurram_spi_engine #(.LANES(LANES_A), .CHAIN_LEN(CL_A), .CLK_DIV(DIV_A)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort), .cfg_write(cfg_write), .cfg_read(cfg_read),
    .shift_mult(shift_mult), .in_steps(in_steps), .out_steps(out_steps), .busy(busy_a),
    .in_data(in_data), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .spi_clk(spi_clk_a), .shift_out(shift_out_a), .shift_in(shift_in_a)
`ifdef NEURRAM_SPI_SNAPSHOT_EN
    , .snapshot(snapshot_a)
`endif
  );

  neurram_spi_engine #(.LANES(LANES_B), .CHAIN_LEN(CL_B), .CLK_DIV(DIV_B)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort), .cfg_write(cfg_write), .cfg_read(cfg_read),
    .shift_mult(shift_mult), .in_steps(in_steps), .out_steps(out_steps), .busy(busy_b),
    .in_data(in_data), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .spi_clk(spi_clk_b), .shift_out(shift_out_b), .shift_in(shift_in_b)
`ifdef NEURRAM_SPI_SNAPSHOT_EN
    , .snapshot(snapshot_b)
`endif
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Pushes the word and its per-pulse lane bit vectors, then holds it until accepted
  task automatic send_a(input logic [31:0] w);
    int t;
    logic [LANES_A-1:0] v;
    exp_q.push_back(w);
    for (int i = 0; i < BPW_A; i++) begin
      for (int l = 0; l < LANES_A; l++) v[l] = w[LANES_A*i+l];
      bit_q.push_back(v);
    end
    in_data = w;
    in_valid_a = 1'b1;
    t = 0;
    while (!in_ready_a && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL send_a_timeout: in_ready stayed %b, required 1", in_ready_a);
    end
    @(negedge clk);
    in_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] w);
    int t;
    exp_q.push_back(w);
    in_data = w;
    in_valid_b = 1'b1;
    t = 0;
    while (!in_ready_b && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL send_b_timeout: in_ready stayed %b, required 1", in_ready_b);
    end
    @(negedge clk);
    in_valid_b = 1'b0;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n_cmp++;
    if (busy_a !== 1'b1) begin n_err++; $display("FAIL start_busy: got %b required 1", busy_a); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy_a !== 1'b0)      begin n_err++; $display("FAIL rst_busy: got %b required 0", busy_a); end
    n_cmp++; if (spi_clk_a !== 1'b0)   begin n_err++; $display("FAIL rst_spi_clk: got %b required 0", spi_clk_a); end
    n_cmp++; if (shift_out_a !== 2'b0) begin n_err++; $display("FAIL rst_shift_out: got %b required 0", shift_out_a); end
    n_cmp++; if (in_ready_a !== 1'b0)  begin n_err++; $display("FAIL rst_in_ready: got %b required 0", in_ready_a); end
    n_cmp++; if (out_valid_a !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b required 0", out_valid_a); end
    n_cmp++; if (out_data_a !== 32'h0) begin n_err++; $display("FAIL rst_out_data: got %h required 0", out_data_a); end
    n_cmp++; if (busy_b !== 1'b0)      begin n_err++; $display("FAIL rst_busy_b: got %b required 0", busy_b); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_only();
    int cyc, pulses;
    logic prev;
    logic [LANES_A-1:0] eb;
    cfg_write = 1'b1; cfg_read = 1'b0;
    exp_q.delete(); bit_q.delete();
    pulse_start_a();
    for (int k = 0; k < WPC_A; k++) send_a(32'hAAAA5555 ^ (32'(k) * 32'h01030507));
    cyc = 0; pulses = 0; prev = spi_clk_a;
    while (busy_a && cyc < 3000) begin
      if (spi_clk_a && !prev) begin
        pulses++;
        n_cmp++;
        if (bit_q.size() == 0) begin
          n_err++; $display("FAIL wr_extra_pulse: pulse %0d with no expected bits left", pulses);
        end else begin
          eb = bit_q.pop_front();
          if (shift_out_a !== eb) begin
            n_err++; $display("FAIL wr_lane_bits: pulse %0d got %b required %b", pulses, shift_out_a, eb);
          end
        end
      end
      prev = spi_clk_a;
      cyc++;
      @(negedge clk);
    end
    n_cmp++; if (pulses != CL_A) begin n_err++; $display("FAIL wr_pulses: got %0d required %0d", pulses, CL_A); end
    n_cmp++; if (cyc != 2*CL_A*DIV_A) begin n_err++; $display("FAIL wr_shift_cycles: got %0d required %0d", cyc, 2*CL_A*DIV_A); end
    n_cmp++; if (spi_clk_a !== 1'b0) begin n_err++; $display("FAIL wr_spi_idle: got %b required 0", spi_clk_a); end
    exp_q.delete(); bit_q.delete();
  endtask

  task automatic test_loopback(input int stall_at);
    int got, stalls, t;
    logic rdy;
    cfg_write = 1'b1; cfg_read = 1'b1;
    exp_q.delete(); bit_q.delete();
    pulse_start_a();
    for (int k = 0; k < WPC_A; k++) send_a($urandom);
    got = 0; stalls = 0; t = 0;
    while (got < WPC_A && t < 5000) begin
      rdy = !(stall_at >= 0 && got >= stall_at && stalls < 5);
      out_ready_a = rdy;
      if (out_valid_a) begin
        n_cmp++;
        if (out_data_a !== exp_q[0]) begin
          n_err++; $display("FAIL lb_word%s: idx %0d got %h required %h", rdy ? "" : "_stalled", got, out_data_a, exp_q[0]);
        end
        if (rdy) begin
          void'(exp_q.pop_front());
          got++;
        end else begin
          stalls++;
        end
      end
      t++;
      @(negedge clk);
    end
    out_ready_a = 1'b1;
    if (t >= 5000) begin n_cmp++; n_err++; $display("FAIL lb_timeout: got %0d words required %0d", got, WPC_A); end
    if (stall_at >= 0) begin
      n_cmp++; if (stalls != 5) begin n_err++; $display("FAIL lb_stall_cycles: got %0d required 5", stalls); end
    end
    n_cmp++; if (busy_a !== 1'b0)      begin n_err++; $display("FAIL lb_busy_end: got %b required 0", busy_a); end
    n_cmp++; if (out_valid_a !== 1'b0) begin n_err++; $display("FAIL lb_valid_end: got %b required 0", out_valid_a); end
  endtask

  task automatic test_abort();
    int t, pulses;
    logic prev;
    cfg_write = 1'b1; cfg_read = 1'b0;
    exp_q.delete(); bit_q.delete();
    pulse_start_a();
    for (int k = 0; k < WPC_A; k++) send_a(32'h0F0F_0000 + 32'(k));
    t = 0; pulses = 0; prev = spi_clk_a;
    while (pulses < 10 && t < 200) begin
      @(negedge clk);
      if (spi_clk_a && !prev) pulses++;
      prev = spi_clk_a;
      t++;
    end
    n_cmp++; if (spi_clk_a !== 1'b1) begin n_err++; $display("FAIL abort_setup_hi: got %b required 1", spi_clk_a); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++; if (busy_a !== 1'b0)     begin n_err++; $display("FAIL abort_busy: got %b required 0", busy_a); end
    n_cmp++; if (spi_clk_a !== 1'b0)  begin n_err++; $display("FAIL abort_spi_clk: got %b required 0", spi_clk_a); end
    n_cmp++; if (in_ready_a !== 1'b0) begin n_err++; $display("FAIL abort_in_ready: got %b required 0", in_ready_a); end
    repeat (3) @(negedge clk);
    n_cmp++; if (busy_a !== 1'b0)     begin n_err++; $display("FAIL abort_stays_idle: got %b required 0", busy_a); end
    test_loopback(-1);
  endtask

  task automatic test_reset_load();
    cfg_write = 1'b1; cfg_read = 1'b1;
    exp_q.delete(); bit_q.delete();
    pulse_start_a();
    send_a(32'hFFFF_FFFF);
    send_a(32'h1234_5678);
    send_a(32'h9ABC_DEF0);
    n_cmp++; if (shift_out_a !== 2'b11) begin n_err++; $display("FAIL rl_loaded_bit0: got %b required 11", shift_out_a); end
    in_data = 32'hDEAD_BEEF;
    in_valid_a = 1'b1;
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (busy_a !== 1'b0)      begin n_err++; $display("FAIL rl_busy: got %b required 0", busy_a); end
    n_cmp++; if (in_ready_a !== 1'b0)  begin n_err++; $display("FAIL rl_in_ready: got %b required 0", in_ready_a); end
    n_cmp++; if (shift_out_a !== 2'b0) begin n_err++; $display("FAIL rl_shift_out: got %b required 0", shift_out_a); end
    n_cmp++; if (spi_clk_a !== 1'b0)   begin n_err++; $display("FAIL rl_spi_clk: got %b required 0", spi_clk_a); end
    n_cmp++; if (out_data_a !== 32'h0) begin n_err++; $display("FAIL rl_out_data: got %h required 0", out_data_a); end
    @(negedge clk);
    in_valid_a = 1'b0;
    rst = 1'b0;
    exp_q.delete(); bit_q.delete();
    @(negedge clk);
  endtask

  task automatic test_lanes4();
    int t, r1, period, got;
    logic prev;
    cfg_write = 1'b1; cfg_read = 1'b1;
    exp_q.delete();
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n_cmp++; if (busy_b !== 1'b1) begin n_err++; $display("FAIL l4_busy: got %b required 1", busy_b); end
    for (int k = 0; k < WPC_B; k++) send_b($urandom);
    t = 0; r1 = -1; period = 0; prev = spi_clk_b;
    while (t < 2000) begin
      if (spi_clk_b && !prev) begin
        if (r1 < 0) r1 = t;
        else begin
          period = t - r1;
          break;
        end
      end
      prev = spi_clk_b;
      t++;
      @(negedge clk);
    end
    n_cmp++; if (period != 2*DIV_B) begin n_err++; $display("FAIL l4_spi_period: got %0d required %0d", period, 2*DIV_B); end
    got = 0; t = 0;
    out_ready_b = 1'b1;
    while (got < WPC_B && t < 5000) begin
      if (out_valid_b) begin
        n_cmp++;
        if (out_data_b !== exp_q[0]) begin
          n_err++; $display("FAIL l4_word: idx %0d got %h required %h", got, out_data_b, exp_q[0]);
        end
        void'(exp_q.pop_front());
        got++;
      end
      t++;
      @(negedge clk);
    end
    if (t >= 5000) begin n_cmp++; n_err++; $display("FAIL l4_timeout: got %0d words required %0d", got, WPC_B); end
    n_cmp++; if (busy_b !== 1'b0) begin n_err++; $display("FAIL l4_busy_end: got %b required 0", busy_b); end
  endtask

  initial begin
    test_reset();
    test_write_only();
    test_loopback(-1);
    test_loopback(4);
    test_abort();
    test_reset_load();
    test_lanes4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
